// File: rtl/bin2bcd_seg_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a registered result,
// overflow/z flags and a combinational active-low 7-segment decode per digit.
module bin2bcd_seg_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int LZB    = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    v,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0] seg,
    output logic                z,
    output logic                ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    shreg;
    logic [4*DIGITS-1:0] work, work_adj, work_nxt;
    logic                carry, ovf_work, upper_nz, last_shift;
    logic [CW-1:0]       cnt;
    logic [3:0]          digit;
    logic                seen, blank;

    assign last_shift = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // One double-dabble step; the bit pushed out of the top digit is the overflow carry.
    always_comb begin
        work_adj = work;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5) work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
        end
        {carry, work_nxt} = {work_adj, shreg[WIDTH-1]};
        upper_nz = 1'b0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            upper_nz = upper_nz | (work_nxt[4*k +: 4] != 4'd0);
        end
    end

    // The result registers are loaded on the final shift edge so that bcd/z/ovf
    // are already valid during the DONE cycle in which done is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            work     <= '0;
            ovf_work <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            z        <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= v;
                        work     <= '0;
                        ovf_work <= 1'b0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    shreg    <= shreg << 1;
                    work     <= work_nxt;
                    ovf_work <= ovf_work | carry;
                    cnt      <= cnt + CW'(1);
                    if (last_shift) begin
                        bcd <= work_nxt;
                        ovf <= ovf_work | carry;
                        z   <= upper_nz | ovf_work | carry;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Walk from the most significant digit down; blanking stops at the first non-zero digit.
    always_comb begin
        seg   = '1;
        seen  = 1'b0;
        digit = '0;
        blank = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = bcd[4*(DIGITS-1-i) +: 4];
            if (digit != 4'd0) seen = 1'b1;
            blank = (LZB != 0) && !seen && (i != DIGITS - 1);
            seg[7*(DIGITS-1-i) +: 7] = blank ? 7'b1111111 : seg7(digit);
        end
    end

endmodule
